// File: rtl/ads1115_scan_sequencer.sv
// ads1115_scan_sequencer: periodic single-shot scan of ADS1115 AIN0..AIN3 through the I2C
// register-access master, emitting one tagged sample per completed channel.
module ads1115_scan_sequencer #(
   parameter int unsigned SCAN_PERIOD = 5_000_000,
   parameter int unsigned POLL_GAP    = 50_000,
   parameter int unsigned POLL_LIMIT  = 20,
   parameter logic [2:0]  PGA         = 3'b001,
   parameter logic [2:0]  DR          = 3'b100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  chan_mask,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_read,
   output logic [1:0]  cmd_ptr,
   output logic [15:0] cmd_wdata,
   input  logic        rsp_valid,
   input  logic        rsp_nack,
   input  logic [15:0] rsp_rdata,
   output logic        sample_valid,
   output logic [1:0]  sample_ch,
   output logic [15:0] sample_data,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_nack,
   output logic        overrun
);
   localparam int unsigned PW = SCAN_PERIOD > 1 ? $clog2(SCAN_PERIOD) : 1;
   localparam int unsigned GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
   localparam int unsigned LW = $clog2(POLL_LIMIT + 1);
   typedef enum logic [3:0] {
      IDLE, CFG_WR, CFG_WAIT, GAP, POLL_RD, POLL_WAIT, DATA_RD, DATA_WAIT, NEXT
   } state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] per_q, per_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [LW-1:0] poll_q, poll_d;
   logic [3:0]    mask_q, mask_d;
   logic [1:0]    ch_q, ch_d;
   logic          smp_v_q, smp_v_d;
   logic [1:0]    smp_ch_q, smp_ch_d;
   logic [15:0]   smp_data_q, smp_data_d;
   logic          err_to_q, err_to_d;
   logic          err_nack_q, err_nack_d;
   logic          ovr_q, ovr_d;
   logic          tick;
   logic [1:0]    first_ch, next_ch;
   logic          has_next;
   assign tick  = per_q == PW'(SCAN_PERIOD - 1);
   assign per_d = tick ? '0 : per_q + 1'b1;
   // Lowest set bit of the live mask starts a scan; lowest captured bit above ch_q continues it.
   always_comb begin
      first_ch = '0;
      next_ch  = '0;
      has_next = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (chan_mask[i]) first_ch = 2'(i);
         if (mask_q[i] && i > int'(ch_q)) begin
            next_ch  = 2'(i);
            has_next = 1'b1;
         end
      end
   end
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      poll_d     = poll_q;
      mask_d     = mask_q;
      ch_d       = ch_q;
      smp_v_d    = 1'b0;
      smp_ch_d   = smp_ch_q;
      smp_data_d = smp_data_q;
      err_to_d   = err_to_q;
      err_nack_d = err_nack_q;
      ovr_d      = ovr_q | (tick & (state_q != IDLE));
      case (state_q)
         IDLE:
            if (tick && chan_mask != 4'b0) begin
               mask_d  = chan_mask;
               ch_d    = first_ch;
               state_d = CFG_WR;
            end
         CFG_WR:  state_d = cmd_ready ? CFG_WAIT : CFG_WR;
         CFG_WAIT:
            if (rsp_valid) begin
               poll_d     = '0;
               gap_d      = '0;
               err_nack_d = err_nack_q | rsp_nack;
               state_d    = rsp_nack ? NEXT : GAP;
            end
         GAP: begin
            gap_d   = gap_q + 1'b1;
            state_d = gap_q == GW'(POLL_GAP - 1) ? POLL_RD : GAP;
         end
         POLL_RD: state_d = cmd_ready ? POLL_WAIT : POLL_RD;
         POLL_WAIT:
            if (rsp_valid) begin
               gap_d  = '0;
               poll_d = poll_q + 1'b1;
               if (rsp_nack) begin
                  err_nack_d = 1'b1;
                  state_d    = NEXT;
               end else if (rsp_rdata[15]) begin
                  state_d = DATA_RD;
               end else if (poll_q + 1'b1 == LW'(POLL_LIMIT)) begin
                  err_to_d = 1'b1;
                  state_d  = NEXT;
               end else begin
                  state_d = GAP;
               end
            end
         DATA_RD: state_d = cmd_ready ? DATA_WAIT : DATA_RD;
         DATA_WAIT:
            if (rsp_valid) begin
               state_d    = NEXT;
               err_nack_d = err_nack_q | rsp_nack;
               smp_v_d    = ~rsp_nack;
               smp_ch_d   = rsp_nack ? smp_ch_q : ch_q;
               smp_data_d = rsp_nack ? smp_data_q : rsp_rdata;
            end
         NEXT: begin
            ch_d    = has_next ? next_ch : ch_q;
            state_d = has_next ? CFG_WR : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         per_q      <= '0;
         gap_q      <= '0;
         poll_q     <= '0;
         mask_q     <= '0;
         ch_q       <= '0;
         smp_v_q    <= 1'b0;
         smp_ch_q   <= '0;
         smp_data_q <= '0;
         err_to_q   <= 1'b0;
         err_nack_q <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_q      <= per_d;
         gap_q      <= gap_d;
         poll_q     <= poll_d;
         mask_q     <= mask_d;
         ch_q       <= ch_d;
         smp_v_q    <= smp_v_d;
         smp_ch_q   <= smp_ch_d;
         smp_data_q <= smp_data_d;
         err_to_q   <= err_to_d;
         err_nack_q <= err_nack_d;
         ovr_q      <= ovr_d;
      end
   end
   // Command fields decode straight from state so reset removes cmd_valid without waiting for a clock.
   assign cmd_valid    = state_q inside {CFG_WR, POLL_RD, DATA_RD};
   assign cmd_read     = state_q inside {POLL_RD, DATA_RD};
   assign cmd_ptr      = state_q inside {CFG_WR, POLL_RD} ? 2'b01 : 2'b00;
   assign cmd_wdata    = state_q == CFG_WR ? {2'b11, ch_q, PGA, 1'b1, DR, 5'b00011} : 16'h0;
   assign busy         = state_q != IDLE;
   assign sample_valid = smp_v_q;
   assign sample_ch    = smp_ch_q;
   assign sample_data  = smp_data_q;
   assign err_timeout  = err_to_q;
   assign err_nack     = err_nack_q;
   assign overrun      = ovr_q;
endmodule

// File: tb/tb_ads1115_scan_sequencer.sv
// tb_ads1115_scan_sequencer: directed bench acting as the I2C register master, one
// transaction at a time, with hand-computed expectations for each scan scenario.
module tb_ads1115_scan_sequencer;
   localparam int SP = 300;
   localparam int PG = 4;
   localparam int PL = 3;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  chan_mask = 4'b0;
   logic        cmd_valid, cmd_read;
   logic        cmd_ready = 1'b0;
   logic [1:0]  cmd_ptr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid = 1'b0;
   logic        rsp_nack = 1'b0;
   logic [15:0] rsp_rdata = 16'h0;
   logic        sample_valid, busy, err_timeout, err_nack, overrun;
   logic [1:0]  sample_ch;
   logic [15:0] sample_data;
   int          tests = 0;
   int          fails = 0;
   ads1115_scan_sequencer #(.SCAN_PERIOD(SP), .POLL_GAP(PG), .POLL_LIMIT(PL)) dut (
      .clk(clk), .rst_n(rst_n), .chan_mask(chan_mask),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_ptr(cmd_ptr),
      .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
      .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
      .busy(busy), .err_timeout(err_timeout), .err_nack(err_nack), .overrun(overrun)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wait_cmd(input string tag, output bit ok);
      int n = 0;
      while (!cmd_valid && n < 1000) begin
         @(negedge clk);
         n++;
      end
      ok = cmd_valid;
      if (!ok) chk({tag, "_timeout"}, 32'(cmd_valid), 32'd1);
   endtask
   // One register transaction: check the request, optionally stall ready, then answer.
   task automatic serve(input string tag, input bit rd, input logic [1:0] ptr, input logic [15:0] wd,
                        input logic [15:0] rdata, input bit nack, input int lag);
      logic [19:0] exp;
      bit ok;
      wait_cmd(tag, ok);
      if (!ok) return;
      exp = {1'b1, rd, ptr, rd ? 16'h0 : wd};
      chk({tag, "_cmd"}, {cmd_valid, cmd_read, cmd_ptr, cmd_read ? 16'h0 : cmd_wdata}, exp);
      for (int i = 0; i < lag; i++) begin
         @(negedge clk);
         chk({tag, "_stall"}, {cmd_valid, cmd_read, cmd_ptr, cmd_read ? 16'h0 : cmd_wdata}, exp);
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk({tag, "_vdrop"}, 32'(cmd_valid), 32'd0);
      rsp_valid = 1'b1;
      rsp_nack  = nack;
      rsp_rdata = rdata;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_rdata = 16'h0;
   endtask
   task automatic smp(input string tag, input logic [1:0] ch, input logic [15:0] data);
      chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
      chk({tag, "_ch"}, 32'(sample_ch), 32'(ch));
      chk({tag, "_data"}, 32'(sample_data), 32'(data));
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_cmd"}, {cmd_valid, cmd_read, cmd_ptr, cmd_wdata}, 32'd0);
      chk({tag, "_stat"}, {sample_valid, sample_ch, sample_data, busy, err_timeout, err_nack, overrun}, 32'd0);
   endtask
   initial begin
      int n;
      bit ok;
      chan_mask = 4'b0101;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_valid && n < 1000);
      chk("first_tick", n, SP);
      // Mask 0101: ch0 and ch2, OS set on the second poll.
      serve("t1_cfg0", 0, 2'b01, 16'hC383, 16'h0, 0, 0);
      serve("t1_poll0a", 1, 2'b01, 16'h0, 16'h7FFF, 0, 0);
      serve("t1_poll0b", 1, 2'b01, 16'h0, 16'h8000, 0, 0);
      serve("t1_data0", 1, 2'b00, 16'h0, 16'h1234, 0, 0);
      smp("t1_s0", 2'd0, 16'h1234);
      @(negedge clk);
      chk("t1_pulse", 32'(sample_valid), 32'd0);
      chk("t1_hold", 32'(sample_data), 32'h1234);
      serve("t1_cfg2", 0, 2'b01, 16'hE383, 16'h0, 0, 0);
      serve("t1_poll2a", 1, 2'b01, 16'h0, 16'h0000, 0, 0);
      serve("t1_poll2b", 1, 2'b01, 16'h0, 16'hFFFF, 0, 0);
      serve("t1_data2", 1, 2'b00, 16'h0, 16'h0ABC, 0, 0);
      smp("t1_s2", 2'd2, 16'h0ABC);
      @(negedge clk);
      chk("t1_idle", {busy, err_timeout, err_nack, overrun}, 32'd0);
      // A response with nothing outstanding must be ignored.
      rsp_valid = 1'b1;
      rsp_nack  = 1'b1;
      rsp_rdata = 16'h8000;
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      rsp_rdata = 16'h0;
      @(negedge clk);
      chk("stray_rsp", {sample_valid, busy, err_nack}, 32'd0);
      // Mask 0011: ch0 never completes, ch1 still scanned.
      chan_mask = 4'b0011;
      serve("t2_cfg0", 0, 2'b01, 16'hC383, 16'h0, 0, 0);
      serve("t2_poll0a", 1, 2'b01, 16'h0, 16'h7FFF, 0, 0);
      serve("t2_poll0b", 1, 2'b01, 16'h0, 16'h0000, 0, 0);
      chk("t2_no_to_yet", 32'(err_timeout), 32'd0);
      serve("t2_poll0c", 1, 2'b01, 16'h0, 16'h7FFF, 0, 0);
      chk("t2_timeout", 32'(err_timeout), 32'd1);
      chk("t2_nosample", 32'(sample_valid), 32'd0);
      serve("t2_cfg1", 0, 2'b01, 16'hD383, 16'h0, 0, 0);
      serve("t2_poll1", 1, 2'b01, 16'h0, 16'h8000, 0, 0);
      serve("t2_data1", 1, 2'b00, 16'h0, 16'h8001, 0, 0);
      smp("t2_s1", 2'd1, 16'h8001);
      @(negedge clk);
      chk("t2_idle", 32'(busy), 32'd0);
      // Mask 0011 again: NACK on ch1 config write.
      serve("t3_cfg0", 0, 2'b01, 16'hC383, 16'h0, 0, 0);
      serve("t3_poll0", 1, 2'b01, 16'h0, 16'h8000, 0, 0);
      serve("t3_data0", 1, 2'b00, 16'h0, 16'h5A5A, 0, 0);
      smp("t3_s0", 2'd0, 16'h5A5A);
      chk("t3_nack_pre", 32'(err_nack), 32'd0);
      serve("t3_cfg1", 0, 2'b01, 16'hD383, 16'h0, 1, 0);
      chk("t3_nack", 32'(err_nack), 32'd1);
      chk("t3_nosample", 32'(sample_valid), 32'd0);
      @(negedge clk);
      chk("t3_idle", {busy, cmd_valid, err_timeout}, 32'd1);
      // Mask 1000 with long stalls: overrun, scan continues where it was.
      chan_mask = 4'b1000;
      serve("t4_cfg3", 0, 2'b01, 16'hF383, 16'h0, 0, 10);
      chan_mask = 4'b0001;
      chk("t4_ovr_pre", 32'(overrun), 32'd0);
      serve("t4_poll3", 1, 2'b01, 16'h0, 16'h8000, 0, SP + 20);
      chk("t4_overrun", 32'(overrun), 32'd1);
      chan_mask = 4'b0000;
      serve("t4_data3", 1, 2'b00, 16'h0, 16'h0F0F, 0, 0);
      smp("t4_s3", 2'd3, 16'h0F0F);
      @(negedge clk);
      chk("t4_idle", 32'(busy), 32'd0);
      // Empty mask: three ticks pass with no activity.
      n = 0;
      for (int i = 0; i < 3 * SP + 10; i++) begin
         @(negedge clk);
         if (cmd_valid || busy) n++;
      end
      chk("t5_quiet", n, 0);
      // Reset while a poll read is outstanding.
      chan_mask = 4'b0001;
      serve("t6_cfg0", 0, 2'b01, 16'hC383, 16'h0, 0, 0);
      wait_cmd("t6_poll", ok);
      chk("t6_poll_cmd", {cmd_valid, cmd_read, cmd_ptr}, 32'b1101);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("t6_in_wait", {cmd_valid, busy}, 32'b01);
      #2 rst_n = 1'b0;
      #1 chk_zero("t6_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmd_valid && n < 1000);
      chk("t6_restart", n, SP);
      chk("t6_cfg", {cmd_valid, cmd_read, cmd_ptr, cmd_wdata}, {4'b1001, 16'hC383});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
